vec_alu_sequencer: RTL and testbench

VEC_ALU_SEQUENCER -- requirements
Module: vec_alu_sequencer

---
 rtl/vec_alu_sequencer_if.sv | 53 +++++
 rtl/vec_alu_sequencer.sv | 127 ++++++++++++
 tb/tb_vec_alu_sequencer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_alu_sequencer_if.sv
// Bundle of command, register-file, ALU and status signals around vec_alu_sequencer.
// master: command source / register file / ALU side; slave: the sequencer.
interface vec_alu_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic        cmd_sign;
   logic [4:0]  cmd_shamt;
   logic [3:0]  cmd_src_a;
   logic [3:0]  cmd_src_b;
   logic [3:0]  cmd_dst;
   logic [4:0]  cmd_len;

   logic [7:0]  rf_rd_addr_a;
   logic [7:0]  rf_rd_addr_b;
   logic [31:0] rf_rd_data_a;
   logic [31:0] rf_rd_data_b;
   logic        rf_wr_en;
   logic [7:0]  rf_wr_addr;
   logic [31:0] rf_wr_data;

   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [4:0]  alu_shamt;
   logic [3:0]  alu_op;
   logic        alu_use_sign;
   logic [31:0] alu_res;
   logic        alu_zero;
   logic        alu_overflow;
   logic        alu_cout;

   logic        busy;
   logic        done;
   logic        flag_overflow;
   logic        flag_zero;
   logic        flag_cout;

   modport master (
      output cmd_valid, cmd_op, cmd_sign, cmd_shamt, cmd_src_a, cmd_src_b, cmd_dst, cmd_len,
      output rf_rd_data_a, rf_rd_data_b, alu_res, alu_zero, alu_overflow, alu_cout,
      input  cmd_ready, rf_rd_addr_a, rf_rd_addr_b, rf_wr_en, rf_wr_addr, rf_wr_data,
      input  alu_a, alu_b, alu_shamt, alu_op, alu_use_sign,
      input  busy, done, flag_overflow, flag_zero, flag_cout
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_sign, cmd_shamt, cmd_src_a, cmd_src_b, cmd_dst, cmd_len,
      input  rf_rd_data_a, rf_rd_data_b, alu_res, alu_zero, alu_overflow, alu_cout,
      output cmd_ready, rf_rd_addr_a, rf_rd_addr_b, rf_wr_en, rf_wr_addr, rf_wr_data,
      output alu_a, alu_b, alu_shamt, alu_op, alu_use_sign,
      output busy, done, flag_overflow, flag_zero, flag_cout
   );
endinterface

// File: rtl/vec_alu_sequencer.sv
// Streams up to 16 vector elements through an external ALU: issue, read return, write back.
// Optional summary flags are built only when VEC_SEQ_FLAGS_EN is defined.
module vec_alu_sequencer (
   input logic               i_clk,
   input logic               i_rst,
   vec_alu_sequencer_if.slave io_bus
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e      r_state, w_state_d;
   logic [3:0]  r_op, r_src_a, r_src_b, r_dst;
   logic        r_sign;
   logic [4:0]  r_shamt, r_len;
   logic [3:0]  r_issue_idx, r_rd_idx, r_wr_idx;
   logic        r_rd_vld, r_rd_last, r_wr_vld, r_wr_last, r_noop_done;
   logic [31:0] r_wr_data;
   logic        w_accept, w_issue_last, w_final_wr;
   logic [4:0]  w_eff_len;

   assign w_accept     = (r_state == StIdle) && io_bus.cmd_valid;
   assign w_eff_len    = (io_bus.cmd_len > 5'd16) ? 5'd16 : io_bus.cmd_len;
   assign w_issue_last = (({1'b0, r_issue_idx} + 5'd1) == r_len);
   assign w_final_wr   = r_wr_vld && r_wr_last;

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle:  if (w_accept && (w_eff_len != 5'd0)) w_state_d = StRun;
         StRun:   if (w_issue_last) w_state_d = StDrain;
         StDrain: if (w_final_wr) w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= StIdle;
      else       r_state <= w_state_d;
   end

   // Issue -> read return (ALU evaluated) -> registered write stage.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_op        <= '0;
         r_sign      <= 1'b0;
         r_shamt     <= '0;
         r_src_a     <= '0;
         r_src_b     <= '0;
         r_dst       <= '0;
         r_len       <= '0;
         r_issue_idx <= '0;
         r_rd_vld    <= 1'b0;
         r_rd_idx    <= '0;
         r_rd_last   <= 1'b0;
         r_wr_vld    <= 1'b0;
         r_wr_idx    <= '0;
         r_wr_last   <= 1'b0;
         r_wr_data   <= '0;
         r_noop_done <= 1'b0;
      end else begin
         r_noop_done <= w_accept && (w_eff_len == 5'd0);
         if (w_accept) begin
            r_op    <= io_bus.cmd_op;
            r_sign  <= io_bus.cmd_sign;
            r_shamt <= io_bus.cmd_shamt;
            r_src_a <= io_bus.cmd_src_a;
            r_src_b <= io_bus.cmd_src_b;
            r_dst   <= io_bus.cmd_dst;
            r_len   <= w_eff_len;
         end
         if (r_state == StRun) r_issue_idx <= w_issue_last ? 4'd0 : r_issue_idx + 4'd1;
         r_rd_vld  <= (r_state == StRun);
         r_rd_idx  <= r_issue_idx;
         r_rd_last <= (r_state == StRun) && w_issue_last;
         r_wr_vld  <= r_rd_vld;
         r_wr_idx  <= r_rd_vld ? r_rd_idx : 4'd0;
         r_wr_last <= r_rd_last;
         r_wr_data <= r_rd_vld ? io_bus.alu_res : 32'd0;
      end
   end

   assign io_bus.cmd_ready    = (r_state == StIdle);
   assign io_bus.busy         = (r_state != StIdle);
   assign io_bus.rf_rd_addr_a = (r_state == StRun) ? {r_src_a, r_issue_idx} : 8'd0;
   assign io_bus.rf_rd_addr_b = (r_state == StRun) ? {r_src_b, r_issue_idx} : 8'd0;
   assign io_bus.alu_a        = io_bus.rf_rd_data_a;
   assign io_bus.alu_b        = io_bus.rf_rd_data_b;
   assign io_bus.alu_op       = r_op;
   assign io_bus.alu_use_sign = r_sign;
   assign io_bus.alu_shamt    = r_shamt;
   assign io_bus.rf_wr_en     = r_wr_vld;
   assign io_bus.rf_wr_addr   = r_wr_vld ? {r_dst, r_wr_idx} : 8'd0;
   assign io_bus.rf_wr_data   = r_wr_vld ? r_wr_data : 32'd0;
   assign io_bus.done         = r_noop_done || w_final_wr;

`ifdef VEC_SEQ_FLAGS_EN
   logic r_flag_zero, r_flag_overflow, r_flag_cout;

   // Flags fold in each element as its ALU result enters the write stage.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_flag_zero     <= 1'b0;
         r_flag_overflow <= 1'b0;
         r_flag_cout     <= 1'b0;
      end else if (w_accept) begin
         r_flag_zero     <= 1'b1;
         r_flag_overflow <= 1'b0;
         r_flag_cout     <= 1'b0;
      end else if (r_rd_vld) begin
         r_flag_zero     <= r_flag_zero & io_bus.alu_zero;
         r_flag_overflow <= r_flag_overflow | io_bus.alu_overflow;
         r_flag_cout     <= r_flag_cout | io_bus.alu_cout;
      end
   end

   assign io_bus.flag_zero     = r_flag_zero;
   assign io_bus.flag_overflow = r_flag_overflow;
   assign io_bus.flag_cout     = r_flag_cout;
`else
   logic w_unused_alu_flags;
   assign w_unused_alu_flags   = io_bus.alu_zero ^ io_bus.alu_overflow ^ io_bus.alu_cout;
   assign io_bus.flag_zero     = 1'b0;
   assign io_bus.flag_overflow = 1'b0;
   assign io_bus.flag_cout     = 1'b0;
`endif

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Bench for vec_alu_sequencer: register file + ALU models, command-level reference, random stimulus.
module tb_vec_alu_sequencer;

`ifdef VEC_SEQ_FLAGS_EN
   localparam bit FlagsEn = 1'b1;
`else
   localparam bit FlagsEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vec_alu_sequencer_if bus ();

   vec_alu_sequencer dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus)
   );

   logic [31:0] rf_mem  [256];
   logic [31:0] ref_mem [256];
   logic        poke_en;
   logic [7:0]  poke_addr;
   logic [31:0] poke_data;
   int          n_checks = 0;
   int          n_fail = 0;

   // Reference ALU: {overflow, cout, result}
   function automatic logic [33:0] alu_f(input logic [3:0] op, input logic sgn,
                                         input logic [4:0] sh, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [32:0] s;
      logic [31:0] r;
      logic        c, v;
      r = a;
      c = 1'b0;
      v = 1'b0;
      case (op)
         4'd0: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0];
            c = s[32];
            v = sgn ? ((a[31] == b[31]) && (r[31] != a[31])) : c;
         end
         4'd1: begin
            r = a - b;
            c = (a < b);
            v = sgn ? ((a[31] != b[31]) && (r[31] != a[31])) : c;
         end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = a << sh;
         4'd6: r = sgn ? 32'($signed(a) >>> sh) : (a >> sh);
         4'd7: r = b;
         default: r = a;
      endcase
      return {v, c, r};
   endfunction

   logic [33:0] alu_out;
   always_comb begin
      alu_out          = alu_f(bus.alu_op, bus.alu_use_sign, bus.alu_shamt, bus.alu_a, bus.alu_b);
      bus.alu_res      = alu_out[31:0];
      bus.alu_cout     = alu_out[32];
      bus.alu_overflow = alu_out[33];
      bus.alu_zero     = (alu_out[31:0] == 32'd0);
   end

   // Register file: one-cycle read latency, old data on same-edge read/write.
   always @(posedge clk) begin
      bus.rf_rd_data_a <= rf_mem[bus.rf_rd_addr_a];
      bus.rf_rd_data_b <= rf_mem[bus.rf_rd_addr_b];
      if (poke_en)              rf_mem[poke_addr] <= poke_data;
      else if (bus.rf_wr_en)    rf_mem[bus.rf_wr_addr] <= bus.rf_wr_data;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic poke(input logic [7:0] addr, input logic [31:0] data);
      poke_en   = 1'b1;
      poke_addr = addr;
      poke_data = data;
      ref_mem[addr] = data;
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   // Called at a negedge; returns at a negedge. hold keeps cmd_valid high afterwards.
   task automatic run_cmd(input logic [3:0] op, input logic sgn, input logic [4:0] sh,
                          input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                          input logic [4:0] len, input bit hold, input int abort_at);
      int          n;
      logic [31:0] res [16];
      logic [31:0] opa [16];
      logic [31:0] opb [16];
      logic [33:0] r;
      logic        fz, fo, fc;
      logic [31:0] exp_wd;
      logic [7:0]  exp_wa;
      n  = (len > 5'd16) ? 16 : int'(len);
      fz = 1'b1;
      fo = 1'b0;
      fc = 1'b0;
      for (int i = 0; i < n; i++) begin
         opa[i] = ref_mem[{a, 4'(i)}];
         opb[i] = ref_mem[{b, 4'(i)}];
         r      = alu_f(op, sgn, sh, opa[i], opb[i]);
         res[i] = r[31:0];
         fz     = fz & (r[31:0] == 32'd0);
         fo     = fo | r[33];
         fc     = fc | r[32];
      end
      bus.cmd_op    = op;
      bus.cmd_sign  = sgn;
      bus.cmd_shamt = sh;
      bus.cmd_src_a = a;
      bus.cmd_src_b = b;
      bus.cmd_dst   = d;
      bus.cmd_len   = len;
      bus.cmd_valid = 1'b1;
      check_eq("ready_before_accept", bus.cmd_ready, 1'b1);
      @(posedge clk);
      if (n == 0) begin
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         check_eq("noop_done", bus.done, 1'b1);
         check_eq("noop_ready", bus.cmd_ready, 1'b1);
         check_eq("noop_busy", bus.busy, 1'b0);
         check_eq("noop_wr_en", bus.rf_wr_en, 1'b0);
         check_eq("noop_rd_addr", bus.rf_rd_addr_a, 8'd0);
         check_eq("noop_flag_zero", bus.flag_zero, FlagsEn);
         check_eq("noop_flag_ovf", bus.flag_overflow, 1'b0);
         @(negedge clk);
         check_eq("noop_done_drop", bus.done, 1'b0);
         check_eq("noop_wr_en2", bus.rf_wr_en, 1'b0);
         return;
      end
      for (int c = 1; c <= n + 3; c++) begin
         @(negedge clk);
         if (c == 1 && !hold) bus.cmd_valid = 1'b0;
         check_eq($sformatf("busy c%0d", c), bus.busy, (c <= n + 2));
         check_eq($sformatf("ready c%0d", c), bus.cmd_ready, (c > n + 2));
         check_eq($sformatf("rd_addr_a c%0d", c), bus.rf_rd_addr_a,
                  (c <= n) ? {a, 4'(c - 1)} : 8'd0);
         check_eq($sformatf("rd_addr_b c%0d", c), bus.rf_rd_addr_b,
                  (c <= n) ? {b, 4'(c - 1)} : 8'd0);
         exp_wa = 8'd0;
         exp_wd = 32'd0;
         if (c >= 3 && c <= n + 2) begin
            exp_wa = {d, 4'(c - 3)};
            exp_wd = res[c - 3];
         end
         check_eq($sformatf("wr_en c%0d", c), bus.rf_wr_en, (c >= 3 && c <= n + 2));
         check_eq($sformatf("wr_addr c%0d", c), bus.rf_wr_addr, exp_wa);
         check_eq($sformatf("wr_data c%0d", c), bus.rf_wr_data, exp_wd);
         check_eq($sformatf("done c%0d", c), bus.done, (c == n + 2));
         if (c >= 2 && c <= n + 1) begin
            check_eq($sformatf("alu_a c%0d", c), bus.alu_a, opa[c - 2]);
            check_eq($sformatf("alu_b c%0d", c), bus.alu_b, opb[c - 2]);
         end
         if (c == 2) begin
            check_eq("alu_op", bus.alu_op, op);
            check_eq("alu_use_sign", bus.alu_use_sign, sgn);
            check_eq("alu_shamt", bus.alu_shamt, sh);
         end
         if (c == n + 2) begin
            check_eq("flag_zero", bus.flag_zero, FlagsEn & fz);
            check_eq("flag_overflow", bus.flag_overflow, FlagsEn & fo);
            check_eq("flag_cout", bus.flag_cout, FlagsEn & fc);
         end
         if (c == abort_at) begin
            rst = 1'b1;
            bus.cmd_valid = 1'b1;
            for (int i = 0; i <= abort_at - 3 && i < n; i++) ref_mem[{d, 4'(i)}] = res[i];
            for (int k = 0; k < 2; k++) begin
               @(negedge clk);
               check_eq("abort_wr_en", bus.rf_wr_en, 1'b0);
               check_eq("abort_done", bus.done, 1'b0);
               check_eq("abort_busy", bus.busy, 1'b0);
               check_eq("abort_ready", bus.cmd_ready, 1'b1);
               check_eq("abort_flag_zero", bus.flag_zero, 1'b0);
            end
            rst = 1'b0;
            bus.cmd_valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               check_eq("post_abort_idle", bus.busy, 1'b0);
               check_eq("post_abort_wr_en", bus.rf_wr_en, 1'b0);
            end
            return;
         end
      end
      for (int i = 0; i < n; i++) ref_mem[{d, 4'(i)}] = res[i];
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int mism;
      rst = 1'b1;
      poke_en = 1'b0;
      poke_addr = '0;
      poke_data = '0;
      bus.cmd_valid = 1'b1;
      bus.cmd_op = 4'd0;
      bus.cmd_sign = 1'b0;
      bus.cmd_shamt = 5'd0;
      bus.cmd_src_a = 4'd1;
      bus.cmd_src_b = 4'd2;
      bus.cmd_dst = 4'd3;
      bus.cmd_len = 5'd4;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", bus.busy, 1'b0);
      check_eq("rst_ready", bus.cmd_ready, 1'b1);
      check_eq("rst_done", bus.done, 1'b0);
      check_eq("rst_wr_en", bus.rf_wr_en, 1'b0);
      check_eq("rst_wr_addr", bus.rf_wr_addr, 8'd0);
      check_eq("rst_rd_addr", bus.rf_rd_addr_a, 8'd0);
      check_eq("rst_flag_zero", bus.flag_zero, 1'b0);
      check_eq("rst_flag_cout", bus.flag_cout, 1'b0);
      for (int i = 0; i < 256; i++) poke(8'(i), $urandom);
      rst = 1'b0;
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      check_eq("idle_after_rst", bus.busy, 1'b0);

      // ADD signed, N=4
      for (int i = 0; i < 4; i++) begin
         poke({4'd1, 4'(i)}, 32'(i + 1));
         poke({4'd3, 4'(i)}, 32'(10 * (i + 1)));
      end
      run_cmd(4'd0, 1'b1, 5'd0, 4'd1, 4'd3, 4'd2, 5'd4, 1'b0, 0);
      for (int i = 0; i < 4; i++) check_eq("add_vec", rf_mem[8'h20 + 8'(i)], 32'(11 * (i + 1)));
      check_eq("add_flag_zero_held", bus.flag_zero, 1'b0);

      // SUB unsigned 0 - 1
      poke(8'h40, 32'd0);
      poke(8'h60, 32'd1);
      run_cmd(4'd1, 1'b0, 5'd0, 4'd4, 4'd6, 4'd7, 5'd1, 1'b0, 0);
      check_eq("sub_result", rf_mem[8'h70], 32'hFFFF_FFFF);
      check_eq("sub_flag_cout", bus.flag_cout, FlagsEn);
      check_eq("sub_flag_ovf", bus.flag_overflow, FlagsEn);

      // Zero length, then clamped length
      run_cmd(4'd0, 1'b0, 5'd0, 4'd8, 4'd9, 4'd10, 5'd0, 1'b0, 0);
      run_cmd(4'd4, 1'b0, 5'd0, 4'd8, 4'd9, 4'd10, 5'd20, 1'b0, 0);

      // AND in place with all-zero vector
      for (int i = 0; i < 16; i++) poke({4'd5, 4'(i)}, 32'd0);
      run_cmd(4'd2, 1'b0, 5'd0, 4'd5, 4'd5, 4'd5, 5'd16, 1'b0, 0);
      for (int i = 0; i < 16; i++) check_eq("and_zero", rf_mem[{4'd5, 4'(i)}], 32'd0);
      check_eq("and_flag_zero", bus.flag_zero, FlagsEn);

      // Reset mid-run, then a normal command
      run_cmd(4'd0, 1'b0, 5'd0, 4'd1, 4'd2, 4'd9, 5'd8, 1'b0, 3);
      run_cmd(4'd3, 1'b0, 5'd0, 4'd11, 4'd12, 4'd13, 5'd6, 1'b0, 0);

      // Back-to-back with cmd_valid held high
      run_cmd(4'd0, 1'b0, 5'd0, 4'd14, 4'd15, 4'd14, 5'd5, 1'b1, 0);
      run_cmd(4'd0, 1'b0, 5'd0, 4'd14, 4'd15, 4'd14, 5'd5, 1'b0, 0);

      for (int t = 0; t < 25; t++) begin
         run_cmd(4'($urandom_range(0, 8)), 1'($urandom), 5'($urandom),
                 4'($urandom), 4'($urandom), 4'($urandom),
                 5'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), 0);
      end
      bus.cmd_valid = 1'b0;
      @(negedge clk);

      mism = 0;
      for (int i = 0; i < 256; i++) if (rf_mem[i] !== ref_mem[i]) mism++;
      check_eq("mem_image", 32'(mism), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
